// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue register: maps RV32I opcode/funct fields to an ALU op code and registers both operands.
// Optional single-level result forwarding is enabled by defining ALU_ISSUE_FORWARD_EN.
module alu_issue_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic [6:0]      in_funct7,
   input  logic [4:0]      in_rs1,
   input  logic [4:0]      in_rs2,
   input  logic [4:0]      in_rd,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] alu_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_operand1,
   output logic [XLEN-1:0] out_operand2,
   output logic [3:0]      out_alu_op,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_NOP  = 4'd15
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // funct3 to op for the base (funct7 = 0) encodings shared by R-type and I-type.
   function automatic alu_op_e base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   endfunction

   alu_op_e         dec_op;
   logic            dec_illegal;
   logic            use_rs1;
   logic            use_rs2;
   logic            use_imm;
   logic [4:0]      dec_rd;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] next_op1;
   logic [XLEN-1:0] next_op2;
   logic            load;

   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready;

   // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      dec_op      = ALU_NOP;
      dec_illegal = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      use_imm     = 1'b0;
      dec_rd      = in_rd;
      case (in_opcode)
         OPC_OP: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            if (in_funct7 == F7_BASE) begin
               dec_op = base_op(in_funct3);
            end else if (in_funct7 == F7_ALT && in_funct3 == 3'b000) begin
               dec_op = ALU_SUB;
            end else if (in_funct7 == F7_ALT && in_funct3 == 3'b101) begin
               dec_op = ALU_SRA;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            use_rs1 = 1'b1;
            use_imm = 1'b1;
            case (in_funct3)
               3'b001: begin
                  if (in_funct7 == F7_BASE) dec_op = ALU_SLL;
                  else                      dec_illegal = 1'b1;
               end
               3'b101: begin
                  if (in_funct7 == F7_BASE)     dec_op = ALU_SRL;
                  else if (in_funct7 == F7_ALT) dec_op = ALU_SRA;
                  else                          dec_illegal = 1'b1;
               end
               default: dec_op = base_op(in_funct3);
            endcase
         end
         OPC_LOAD: begin
            dec_op  = ALU_ADD;
            use_rs1 = 1'b1;
            use_imm = 1'b1;
         end
         OPC_STORE: begin
            dec_op  = ALU_ADD;
            use_rs1 = 1'b1;
            use_imm = 1'b1;
            dec_rd  = 5'd0;
         end
         OPC_LUI: begin
            dec_op  = ALU_ADD;
            use_imm = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase

      // Illegal encodings issue as a NOP with zero operands and no writeback.
      if (dec_illegal) begin
         dec_op  = ALU_NOP;
         use_rs1 = 1'b0;
         use_rs2 = 1'b0;
         use_imm = 1'b0;
         dec_rd  = 5'd0;
      end
   end

`ifdef ALU_ISSUE_FORWARD_EN
   logic fwd_live;

   // The held instruction's result is still in flight; take it instead of the stale register-file value.
   assign fwd_live = out_valid && (out_rd != 5'd0);
   assign rs1_val  = (fwd_live && in_rs1 == out_rd) ? alu_result : in_rs1_data;
   assign rs2_val  = (fwd_live && in_rs2 == out_rd) ? alu_result : in_rs2_data;
`else
   logic unused_fwd_inputs;

   assign unused_fwd_inputs = ^{alu_result, in_rs1, in_rs2};
   assign rs1_val           = in_rs1_data;
   assign rs2_val           = in_rs2_data;
`endif

   always_comb begin
      next_op1 = use_rs1 ? rs1_val : '0;
      if (use_rs2)      next_op2 = rs2_val;
      else if (use_imm) next_op2 = in_imm;
      else              next_op2 = '0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_operand1 <= '0;
         out_operand2 <= '0;
         out_alu_op   <= ALU_NOP;
         out_rd       <= 5'd0;
         out_illegal  <= 1'b0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         out_illegal <= 1'b0;
      end else if (load) begin
         out_valid    <= 1'b1;
         out_operand1 <= next_op1;
         out_operand2 <= next_op2;
         out_alu_op   <= dec_op;
         out_rd       <= dec_rd;
         out_illegal  <= dec_illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode table streamed through a scoreboard plus
// stall, flush, forwarding and asynchronous-reset sequences.
module tb_alu_issue_stage;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] o1;
      logic [31:0] o2;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      exp_t        exp;
   } vec_t;

   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                          ST = 7'b0100011, LU = 7'b0110111, BR = 7'b1100011;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [6:0]  in_opcode, in_funct7;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rs1, in_rs2, in_rd, out_rd;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm, alu_result, out_operand1, out_operand2;
   logic [3:0]  out_alu_op;

   int   tests = 0;
   int   fails = 0;
   int   items = 0;
   exp_t sb[$];
   exp_t cur_exp;
   vec_t vecs[21];

   alu_issue_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_operand1(out_operand1), .out_operand2(out_operand2),
      .out_alu_op(out_alu_op), .out_rd(out_rd), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [3:0] eop, input logic [31:0] eo1,
                               input logic [31:0] eo2, input logic [4:0] erd, input logic eill);
      vec_t v;
      v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd = rd;
      v.d1 = d1; v.d2 = d2; v.imm = imm;
      v.exp.op = eop; v.exp.o1 = eo1; v.exp.o2 = eo2; v.exp.rd = erd; v.exp.ill = eill;
      return v;
   endfunction

   // Present an instruction; the monitor records its expectation if the stage accepts it.
   task automatic present(input vec_t v);
      in_opcode = v.opc; in_funct3 = v.f3; in_funct7 = v.f7;
      in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
      in_rs1_data = v.d1; in_rs2_data = v.d2; in_imm = v.imm;
      cur_exp = v.exp;
      in_valid = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the held instruction when it is consumed, then record any new acceptance.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: op=%0d rd=%0d with empty scoreboard", out_alu_op, out_rd);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("item%0d_op", items), {28'd0, out_alu_op}, {28'd0, e.op});
            check($sformatf("item%0d_op1", items), out_operand1, e.o1);
            check($sformatf("item%0d_op2", items), out_operand2, e.o2);
            check($sformatf("item%0d_rd", items), {27'd0, out_rd}, {27'd0, e.rd});
            check($sformatf("item%0d_ill", items), {31'd0, out_illegal}, {31'd0, e.ill});
            items++;
         end
      end
      if (rst_n && in_valid && in_ready && !flush) sb.push_back(cur_exp);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t a, b, c;

      vecs[0]  = mk(R, 3'd0, 7'h00, 5'd3,  32'd5,        32'd7, 32'd0,        4'd0, 32'd5,        32'd7,        5'd3,  1'b0);
      vecs[1]  = mk(R, 3'd0, 7'h20, 5'd4,  32'd9,        32'd4, 32'd0,        4'd1, 32'd9,        32'd4,        5'd4,  1'b0);
      vecs[2]  = mk(R, 3'd5, 7'h20, 5'd6,  32'h80000000, 32'd3, 32'd0,        4'd7, 32'h80000000, 32'd3,        5'd6,  1'b0);
      vecs[3]  = mk(R, 3'd1, 7'h20, 5'd7,  32'd1,        32'd2, 32'd0,        4'hF, 32'd0,        32'd0,        5'd0,  1'b1);
      vecs[4]  = mk(R, 3'd3, 7'h00, 5'd8,  32'hA,        32'hB, 32'd0,        4'd4, 32'hA,        32'hB,        5'd8,  1'b0);
      vecs[5]  = mk(R, 3'd7, 7'h00, 5'd9,  32'hF0,       32'h3C, 32'd0,       4'd9, 32'hF0,       32'h3C,       5'd9,  1'b0);
      vecs[6]  = mk(R, 3'd2, 7'h00, 5'd10, 32'hFFFFFFFF, 32'd1, 32'd0,        4'd3, 32'hFFFFFFFF, 32'd1,        5'd10, 1'b0);
      vecs[7]  = mk(R, 3'd0, 7'h01, 5'd11, 32'd3,        32'd4, 32'd0,        4'hF, 32'd0,        32'd0,        5'd0,  1'b1);
      vecs[8]  = mk(I, 3'd0, 7'h55, 5'd11, 32'h33,       32'h44, 32'hFFFFFFF0, 4'd0, 32'h33,      32'hFFFFFFF0, 5'd11, 1'b0);
      vecs[9]  = mk(I, 3'd5, 7'h20, 5'd12, 32'h1234,     32'h44, 32'h405,     4'd7, 32'h1234,     32'h405,      5'd12, 1'b0);
      vecs[10] = mk(I, 3'd5, 7'h01, 5'd13, 32'h1234,     32'h44, 32'h405,     4'hF, 32'd0,        32'd0,        5'd0,  1'b1);
      vecs[11] = mk(I, 3'd1, 7'h00, 5'd14, 32'h77,       32'h44, 32'd3,       4'd2, 32'h77,       32'd3,        5'd14, 1'b0);
      vecs[12] = mk(I, 3'd1, 7'h20, 5'd15, 32'h77,       32'h44, 32'h403,     4'hF, 32'd0,        32'd0,        5'd0,  1'b1);
      vecs[13] = mk(I, 3'd4, 7'h7F, 5'd16, 32'h5A,       32'h44, 32'hFFF,     4'd5, 32'h5A,       32'hFFF,      5'd16, 1'b0);
      vecs[14] = mk(I, 3'd6, 7'h00, 5'd17, 32'h5A,       32'h44, 32'h0F,      4'd8, 32'h5A,       32'h0F,       5'd17, 1'b0);
      vecs[15] = mk(LD, 3'd2, 7'h00, 5'd18, 32'h1000,    32'h44, 32'h10,      4'd0, 32'h1000,     32'h10,       5'd18, 1'b0);
      vecs[16] = mk(ST, 3'd2, 7'h00, 5'd19, 32'h2000,    32'h44, 32'hFFFFFFFC, 4'd0, 32'h2000,    32'hFFFFFFFC, 5'd0,  1'b0);
      vecs[17] = mk(LU, 3'd0, 7'h00, 5'd20, 32'hDEAD,    32'h44, 32'h12345000, 4'd0, 32'd0,       32'h12345000, 5'd20, 1'b0);
      vecs[18] = mk(BR, 3'd0, 7'h00, 5'd21, 32'h1,       32'h2, 32'h8,        4'hF, 32'd0,        32'd0,        5'd0,  1'b1);
      vecs[19] = mk(I, 3'd5, 7'h00, 5'd22, 32'hF00,      32'h44, 32'd4,       4'd6, 32'hF00,      32'd4,        5'd22, 1'b0);
      vecs[20] = mk(I, 3'd3, 7'h2A, 5'd23, 32'h9,        32'h44, 32'h1,       4'd4, 32'h9,        32'h1,        5'd23, 1'b0);

      // Reset state, checked both while asserted and after release between edges.
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; alu_result = 32'h0;
      in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
      in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; cur_exp = vecs[0].exp;
      #2;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      #11 rst_n = 1'b1;
      tick();
      check("reset_valid", {31'd0, out_valid}, 32'd0);
      check("reset_op", {28'd0, out_alu_op}, 32'd15);
      check("reset_op1", out_operand1, 32'd0);
      check("reset_op2", out_operand2, 32'd0);
      check("reset_rd", {27'd0, out_rd}, 32'd0);
      check("reset_ill", {31'd0, out_illegal}, 32'd0);

      // Decode table streamed back to back at full throughput.
      for (int i = 0; i < 21; i++) begin
         present(vecs[i]);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("drain_valid", {31'd0, out_valid}, 32'd0);

      // Backpressure: outputs hold, in_ready low, then the waiting instruction loads on release.
      a = mk(R, 3'd4, 7'h00, 5'd5, 32'h11, 32'h22, 32'd0, 4'd5, 32'h11, 32'h22, 5'd5, 1'b0);
      b = mk(R, 3'd6, 7'h00, 5'd6, 32'h33, 32'h44, 32'd0, 4'd8, 32'h33, 32'h44, 5'd6, 1'b0);
      out_ready = 1'b0;
      present(a);
      tick();
      present(b);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("stall%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
         check($sformatf("stall%0d_op1", k), out_operand1, 32'h11);
         check($sformatf("stall%0d_op2", k), out_operand2, 32'h22);
         check($sformatf("stall%0d_op", k), {28'd0, out_alu_op}, 32'd5);
         check($sformatf("stall%0d_rd", k), {27'd0, out_rd}, 32'd5);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("release_op1", out_operand1, 32'h33);
      check("release_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      tick();

      // Forwarding: dependent SUB loads while the producer drains.
      alu_result = 32'h12;
      out_ready  = 1'b0;
      a = mk(R, 3'd0, 7'h00, 5'd3, 32'd1, 32'd2, 32'd0, 4'd0, 32'd1, 32'd2, 5'd3, 1'b0);
`ifdef ALU_ISSUE_FORWARD_EN
      b = mk(R, 3'd0, 7'h20, 5'd4, 32'd0, 32'd0, 32'd0, 4'd1, 32'h12, 32'h12, 5'd4, 1'b0);
`else
      b = mk(R, 3'd0, 7'h20, 5'd4, 32'd0, 32'd0, 32'd0, 4'd1, 32'h0, 32'h0, 5'd4, 1'b0);
`endif
      b.rs1 = 5'd3; b.rs2 = 5'd3;
      present(a);
      tick();
      present(b);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();

      // Same dependency through x0 never forwards.
      out_ready = 1'b0;
      a = mk(R, 3'd0, 7'h00, 5'd0, 32'd1, 32'd2, 32'd0, 4'd0, 32'd1, 32'd2, 5'd0, 1'b0);
      b = mk(R, 3'd0, 7'h20, 5'd4, 32'd0, 32'd0, 32'd0, 4'd1, 32'h0, 32'h0, 5'd4, 1'b0);
      b.rs1 = 5'd0; b.rs2 = 5'd0;
      present(a);
      tick();
      present(b);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();

      // Flush beats a simultaneous load and clears a held illegal flag.
      present(vecs[3]);
      tick();
      check("pre_flush_ill", {31'd0, out_illegal}, 32'd1);
      c = mk(R, 3'd0, 7'h00, 5'd9, 32'hAA, 32'hBB, 32'd0, 4'd0, 32'hAA, 32'hBB, 5'd9, 1'b0);
      present(c);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_ill", {31'd0, out_illegal}, 32'd0);
      tick();
      tick();
      check("flush_dropped", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset between edges while an instruction is held.
      out_ready = 1'b0;
      present(a);
      tick();
      in_valid = 1'b0;
      check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_valid", {31'd0, out_valid}, 32'd0);
      check("async_reset_op", {28'd0, out_alu_op}, 32'd15);
      check("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
      sb.delete();
      #4 rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();

      check("scoreboard_empty", sb.size(), 32'd0);
      check("items_compared", items, 32'd28);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
